// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper datapath: grid size default, flood
// engine state encoding, neighbour direction offsets and the tile index type.
package minesweeper_pkg;

    localparam int GRID_SIZE_DEFAULT  = 8;
    localparam int INDEX_BITS_DEFAULT = $clog2(GRID_SIZE_DEFAULT * GRID_SIZE_DEFAULT);

    typedef logic [INDEX_BITS_DEFAULT-1:0] tile_index_t;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        EXPAND
    } state_t;

    // Direction 0..7 walks the 3x3 ring row by row, skipping the centre.
    localparam int DIR_DROW [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
    localparam int DIR_DCOL [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

endpackage

// File: rtl/neighbor_mine_counter.sv
// Combinational count of mines in the 3x3 ring around a tile (centre excluded).
// Neighbours that fall off the grid edge, including across a row wrap, are ignored.
module neighbor_mine_counter
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE   = GRID_SIZE_DEFAULT,
    parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int INDEX_BITS  = $clog2(TOTAL_TILES)
) (
    input  logic [TOTAL_TILES-1:0] mine_map,
    input  logic [INDEX_BITS-1:0]  index,
    output logic [3:0]             count
);

    int row;
    int col;
    int nr;
    int nc;

    // Sum the in-bounds neighbour mine bits.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        count = '0;
        nr    = 0;
        nc    = 0;
        row   = int'(index) / GRID_SIZE;
        col   = int'(index) % GRID_SIZE;
        for (int d = 0; d < 8; d++) begin
            nr = row + DIR_DROW[d];
            nc = col + DIR_DCOL[d];
            if (nr >= 0 && nr < GRID_SIZE && nc >= 0 && nc < GRID_SIZE) begin
                if (mine_map[INDEX_BITS'(nr * GRID_SIZE + nc)]) begin
                    count = count + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/flood_reveal_engine.sv
// Tile reveal engine: single-tile reveals, mine hits, and an iterative
// stack-based flood fill from zero-neighbour tiles. Tracks win / game over.
// Optional build macro REVEAL_MINES_ON_LOSS_EN: on a mine hit, every mine
// becomes revealed (revealed_count is left untouched).
module flood_reveal_engine
    import minesweeper_pkg::*;
#(
    parameter int GRID_SIZE   = GRID_SIZE_DEFAULT,
    parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int INDEX_BITS  = $clog2(TOTAL_TILES),
    parameter int NUM_MINES   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   mine_map_valid,
    input  logic [TOTAL_TILES-1:0] mine_map,
    input  logic [TOTAL_TILES-1:0] flag_map,
    input  logic                   reveal_req,
    input  logic [INDEX_BITS-1:0]  reveal_index,
    output logic [TOTAL_TILES-1:0] revealed_map,
    output logic [INDEX_BITS:0]    revealed_count,
    output logic                   busy,
    output logic                   reveal_done,
    output logic                   hit_mine,
    output logic                   win
);

    localparam logic [INDEX_BITS:0] WIN_COUNT = (INDEX_BITS + 1)'(TOTAL_TILES - NUM_MINES);

    state_t                  state;
    state_t                  state_next;
    logic [INDEX_BITS-1:0]   stack [TOTAL_TILES];
    logic [INDEX_BITS:0]     sp;
    logic [TOTAL_TILES-1:0]  queued;
    logic [INDEX_BITS-1:0]   cur;
    logic [2:0]              dir;

    logic                    accept;
    logic                    req_skip;
    logic                    req_mine;
    logic                    req_push;
    logic                    stack_empty;
    logic [INDEX_BITS-1:0]   sp_dec;
    logic [INDEX_BITS-1:0]   top;
    logic                    top_skip;
    logic                    top_zero;
    logic [3:0]              top_count;
    int                      nb_row;
    int                      nb_col;
    logic [INDEX_BITS-1:0]   nb_index;
    logic                    nb_push;
    logic                    push_en;
    logic [INDEX_BITS-1:0]   push_index;

    assign accept   = (state == IDLE) && reveal_req && mine_map_valid && !hit_mine && !win;
    assign req_skip = revealed_map[reveal_index] | flag_map[reveal_index];
    assign req_mine = mine_map[reveal_index];
    assign req_push = accept && !req_skip && !req_mine;

    assign stack_empty = (sp == '0);
    assign sp_dec      = INDEX_BITS'(sp - 1'b1);
    assign top         = stack[sp_dec];
    assign top_skip    = revealed_map[top] | flag_map[top];
    assign top_zero    = (top_count == 4'd0);

    neighbor_mine_counter #(
        .GRID_SIZE   (GRID_SIZE),
        .TOTAL_TILES (TOTAL_TILES),
        .INDEX_BITS  (INDEX_BITS)
    ) u_top_count (
        .mine_map (mine_map),
        .index    (top),
        .count    (top_count)
    );

    // Neighbour of cur in direction dir, and whether it qualifies for a push.
    always_comb begin
        nb_row   = int'(cur) / GRID_SIZE + DIR_DROW[dir];
        nb_col   = int'(cur) % GRID_SIZE + DIR_DCOL[dir];
        nb_index = INDEX_BITS'(nb_row * GRID_SIZE + nb_col);
        nb_push  = 1'b0;
        if (nb_row >= 0 && nb_row < GRID_SIZE && nb_col >= 0 && nb_col < GRID_SIZE) begin
            nb_push = !revealed_map[nb_index] && !flag_map[nb_index] &&
                      !queued[nb_index] && !mine_map[nb_index];
        end
    end

    assign push_en    = req_push || ((state == EXPAND) && nb_push);
    assign push_index = (state == EXPAND) ? nb_index : reveal_index;

    // Stack storage, written on every push.
    // NOTE: the stack array has no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[sp[INDEX_BITS-1:0]] <= push_index;
        end
    end

    // State register with async reset and synchronous new-game clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_push) state_next = POP;
            POP: begin
                if (stack_empty) begin
                    state_next = IDLE;
                end else if (!top_skip && top_zero) begin
                    state_next = EXPAND;
                end
            end
            EXPAND:  if (dir == 3'd7) state_next = POP;
            default: state_next = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: stack pointer, queued bitmap, reveal map and game status.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            sp             <= '0;
            queued         <= '0;
            cur            <= '0;
            dir            <= '0;
            revealed_map   <= '0;
            revealed_count <= '0;
            reveal_done    <= 1'b0;
            hit_mine       <= 1'b0;
            win            <= 1'b0;
        end else if (clear) begin
            sp             <= '0;
            queued         <= '0;
            cur            <= '0;
            dir            <= '0;
            revealed_map   <= '0;
            revealed_count <= '0;
            reveal_done    <= 1'b0;
            hit_mine       <= 1'b0;
            win            <= 1'b0;
        end else begin
            reveal_done <= 1'b0;
            if (!hit_mine && revealed_count == WIN_COUNT) begin
                win <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_skip) begin
                            reveal_done <= 1'b1;
                        end else if (req_mine) begin
`ifdef REVEAL_MINES_ON_LOSS_EN
                            revealed_map <= revealed_map | mine_map;
`else
                            revealed_map[reveal_index] <= 1'b1;
`endif
                            hit_mine    <= 1'b1;
                            reveal_done <= 1'b1;
                        end else begin
                            sp                   <= sp + 1'b1;
                            queued[reveal_index] <= 1'b1;
                        end
                    end
                end
                POP: begin
                    if (stack_empty) begin
                        reveal_done <= 1'b1;
                    end else begin
                        sp          <= sp - 1'b1;
                        queued[top] <= 1'b0;
                        cur         <= top;
                        dir         <= '0;
                        if (!top_skip) begin
                            revealed_map[top] <= 1'b1;
                            revealed_count    <= revealed_count + 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    dir <= dir + 1'b1;
                    if (nb_push) begin
                        sp               <= sp + 1'b1;
                        queued[nb_index] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flood_reveal_engine.sv
// Self-checking bench for flood_reveal_engine (8x8 grid, one mine for win
// detection). A behavioural fixed-point flood model predicts each accepted
// request; predictions are queued and checked when reveal_done pulses.
`timescale 1ns/1ps
module tb_flood_reveal_engine;
    import minesweeper_pkg::*;

    localparam int G         = 8;
    localparam int T         = 64;
    localparam int NUM_MINES = 1;
    localparam logic [6:0] WIN_TARGET = 7'(T - NUM_MINES);
    localparam logic [63:0] ALL_BUT_63 = 64'h7FFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          mine_map_valid;
    logic [T-1:0]  mine_map;
    logic [T-1:0]  flag_map;
    logic          reveal_req;
    tile_index_t   reveal_index;
    logic [T-1:0]  revealed_map;
    logic [6:0]    revealed_count;
    logic          busy;
    logic          reveal_done;
    logic          hit_mine;
    logic          win;

    typedef struct packed {
        logic [63:0] map;
        logic [6:0]  count;
        logic        hit;
        logic        win;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          req_cyc = 0;
    int          done_cyc = 0;
    int          done_pulses = 0;
    int          pulses_before;
    logic [63:0] m_map;
    logic [6:0]  m_count;
    logic        m_hit;
    logic        m_win;

    flood_reveal_engine #(
        .GRID_SIZE (G),
        .NUM_MINES (NUM_MINES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .mine_map_valid (mine_map_valid),
        .mine_map       (mine_map),
        .flag_map       (flag_map),
        .reveal_req     (reveal_req),
        .reveal_index   (reveal_index),
        .revealed_map   (revealed_map),
        .revealed_count (revealed_count),
        .busy           (busy),
        .reveal_done    (reveal_done),
        .hit_mine       (hit_mine),
        .win            (win)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic bit_at(input logic [63:0] v, input int i);
        logic [5:0] k;
        k = 6'(i);
        return v[k];
    endfunction

    function automatic int nbr_mines(input logic [63:0] mines, input int t);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int r = t / G + dr;
                int c = t % G + dc;
                if ((dr != 0 || dc != 0) && r >= 0 && r < G && c >= 0 && c < G) begin
                    if (bit_at(mines, r * G + c)) n++;
                end
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        m_map   = '0;
        m_count = '0;
        m_hit   = 1'b0;
        m_win   = 1'b0;
    endtask

    // Region grown to a fixed point from idx through zero-count tiles.
    task automatic model_reveal(input int idx);
        logic [63:0] fresh;
        logic        changed;
        if (bit_at(m_map, idx) || bit_at(flag_map, idx)) return;
        if (bit_at(mine_map, idx)) begin
`ifdef REVEAL_MINES_ON_LOSS_EN
            m_map = m_map | mine_map;
`else
            m_map = m_map | (64'd1 << idx);
`endif
            m_hit = 1'b1;
            return;
        end
        fresh = 64'd1 << idx;
        do begin
            changed = 1'b0;
            for (int t = 0; t < T; t++) begin
                if (bit_at(fresh, t) && nbr_mines(mine_map, t) == 0) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            int r = t / G + dr;
                            int c = t % G + dc;
                            int n = r * G + c;
                            if (r >= 0 && r < G && c >= 0 && c < G &&
                                !bit_at(fresh, n) && !bit_at(m_map, n) &&
                                !bit_at(flag_map, n) && !bit_at(mine_map, n)) begin
                                fresh   = fresh | (64'd1 << n);
                                changed = 1'b1;
                            end
                        end
                    end
                end
            end
        end while (changed);
        m_map   = m_map | fresh;
        m_count = m_count + 7'($countones(fresh));
        if (!m_hit && m_count == WIN_TARGET) m_win = 1'b1;
    endtask

    task automatic request(input int idx, input logic expect_accept);
        @(negedge clk);
        reveal_req   = 1'b1;
        reveal_index = 6'(idx);
        req_cyc      = cyc + 1;
        if (expect_accept) begin
            model_reveal(idx);
            exp_q.push_back('{m_map, m_count, m_hit, m_win});
        end
        @(negedge clk);
        reveal_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_settled"}, 64'((busy || exp_q.size() != 0) ? 1 : 0), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_map"},   revealed_map,   64'd0);
        check({tag, "_count"}, 64'(revealed_count), 64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_done"},  64'(reveal_done), 64'd0);
        check({tag, "_hit"},   64'(hit_mine),  64'd0);
        check({tag, "_win"},   64'(win),       64'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        check_zero_outputs("clear");
    endtask

    // Scoreboard consumer: every reveal_done must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && reveal_done) begin
            done_cyc = cyc;
            done_pulses++;
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("done_map",   revealed_map,        exp_e.map);
                check("done_count", 64'(revealed_count), 64'(exp_e.count));
                check("done_hit",   64'(hit_mine),       64'(exp_e.hit));
                check("done_win",   64'(win),            64'(exp_e.win));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        mine_map_valid = 1'b0;
        mine_map       = '0;
        flag_map       = '0;
        reveal_req     = 1'b0;
        reveal_index   = '0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full flood: single mine in the corner, everything else opens; win.
        mine_map       = 64'd1 << 63;
        mine_map_valid = 1'b1;
        pulses_before  = done_pulses;
        request(0, 1'b1);
        wait_idle("flood_all", 3000);
        check("flood_all_map",    revealed_map,        ALL_BUT_63);
        check("flood_all_count",  64'(revealed_count), 64'd63);
        check("flood_all_win",    64'(win),            64'd1);
        check("flood_all_pulses", 64'(done_pulses - pulses_before), 64'd1);
        check("flood_all_busy",   64'(busy),           64'd0);

        // Single numbered tile, plus a request dropped for mine_map_valid low.
        do_clear();
        mine_map       = 64'd1 << 9;
        mine_map_valid = 1'b0;
        pulses_before  = done_pulses;
        request(0, 1'b0);
        repeat (5) @(negedge clk);
        check("invalid_drop_pulses", 64'(done_pulses - pulses_before), 64'd0);
        mine_map_valid = 1'b1;
        request(0, 1'b1);
        wait_idle("single", 50);
        check("single_latency", 64'(done_cyc - req_cyc), 64'd2);
        check("single_map",     revealed_map,        64'd1);
        check("single_count",   64'(revealed_count), 64'd1);
        request(0, 1'b1);
        wait_idle("repeat", 50);
        check("repeat_latency", 64'(done_cyc - req_cyc), 64'd0);

        // Mine hit, then a request that must be ignored.
        do_clear();
        mine_map = 64'd1 << 9;
        request(9, 1'b1);
        wait_idle("hit", 50);
        check("hit_latency", 64'(done_cyc - req_cyc), 64'd0);
        check("hit_flag",    64'(hit_mine),           64'd1);
        check("hit_map",     revealed_map,            64'd1 << 9);
        pulses_before = done_pulses;
        request(0, 1'b0);
        repeat (10) @(negedge clk);
        check("after_hit_pulses", 64'(done_pulses - pulses_before), 64'd0);
        check("after_hit_map",    revealed_map, m_map);

        // Flag blocks a tile; a request while busy is dropped.
        do_clear();
        mine_map      = 64'd1 << 63;
        flag_map      = 64'd1 << 27;
        pulses_before = done_pulses;
        request(0, 1'b1);
        check("flag_busy", 64'(busy), 64'd1);
        request(5, 1'b0);
        wait_idle("flag", 3000);
        check("flag_map",    revealed_map, ~((64'd1 << 27) | (64'd1 << 63)));
        check("flag_count",  64'(revealed_count), 64'd62);
        check("flag_pulses", 64'(done_pulses - pulses_before), 64'd1);
        request(27, 1'b1);
        wait_idle("flagged_req", 50);
        flag_map = '0;

        // Reset in the middle of a flood, then rerun.
        do_clear();
        mine_map = 64'd1 << 63;
        request(0, 1'b1);
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("mid_rst");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        request(0, 1'b1);
        wait_idle("rerun", 3000);
        check("rerun_map", revealed_map, ALL_BUT_63);
        check("rerun_win", 64'(win),     64'd1);

        // Two mines, hit one.
        do_clear();
        mine_map = (64'd1 << 9) | (64'd1 << 20);
        request(20, 1'b1);
        wait_idle("loss", 50);
`ifdef REVEAL_MINES_ON_LOSS_EN
        check("loss_map", revealed_map, (64'd1 << 9) | (64'd1 << 20));
`else
        check("loss_map", revealed_map, 64'd1 << 20);
`endif
        check("loss_count", 64'(revealed_count), 64'd0);
        check("loss_hit",   64'(hit_mine),       64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flood_reveal_engine.md
Name: flood_reveal_engine

Overview:
- Consumes the mine placement mask and its done flag from the mine generator. Services tile-reveal requests from the input/cursor controller.
- A request on a zero-neighbour tile performs an iterative flood fill using an explicit stack.
- Produces the revealed-tile map for the display stage, plus game-over and win status for the game controller.

Parameters:
GRID_SIZE, 8, tiles per row/column
TOTAL_TILES, GRID_SIZE*GRID_SIZE, tile count
INDEX_BITS, $clog2(TOTAL_TILES), tile index width
NUM_MINES, 10, mines in map; used for win detection

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
clear  in  1  synchronous new-game clear
mine_map_valid  in  1  generator done; mine_map stable while high
mine_map  in  TOTAL_TILES  mine mask, bit i = tile i
flag_map  in  TOTAL_TILES  player flags; flagged tiles never revealed
reveal_req  in  1  single-cycle request pulse
reveal_index  in  INDEX_BITS  tile to reveal (row*GRID_SIZE+col)
revealed_map  out  TOTAL_TILES  revealed tiles
revealed_count  out  INDEX_BITS+1  number of revealed tiles
busy  out  1  high outside IDLE
reveal_done  out  1  one-cycle pulse, one per accepted request
hit_mine  out  1  sticky game over
win  out  1  sticky win

Behaviour:
- Reset values: all outputs 0, stack empty, queued bitmap 0, state IDLE. Reset mid-flood aborts immediately.
- clear: synchronous, has priority over all other activity. Same effect as reset, in any state.
- States: IDLE, POP, EXPAND.
- Acceptance: a request is accepted only when all hold:
  - state is IDLE;
  - reveal_req=1 and mine_map_valid=1;
  - hit_mine=0 and win=0.
- Requests not accepted are dropped silently; there is no queueing and no reveal_done.
- IDLE, accepted, tile already revealed or flagged: reveal_done pulses at the next edge; no other change.
- IDLE, accepted, mine tile: at the same edge set the revealed bit, hit_mine and reveal_done; stay in IDLE.
- IDLE, accepted, otherwise: push the index, set its queued bit, go to POP.
- POP, stack empty: pulse reveal_done, go to IDLE.
- POP, stack not empty: pop the top entry (cur) and clear its queued bit.
  - If cur is revealed or flagged, stay in POP.
  - Otherwise set revealed bit, increment revealed_count.
  - If the 3x3 neighbour mine count of cur is 0, go to EXPAND with dir=0; else stay in POP.
- EXPAND: one direction per cycle, dir 0..7 = (-1,-1),(-1,0),(-1,1),(0,-1),(0,1),(1,-1),(1,0),(1,1).
  - Push the neighbour only if it is in-bounds, not revealed, not flagged, not queued, and not a mine. Set its queued bit on push.
  - No row wrap: column 0 has no west neighbours; column GRID_SIZE-1 has no east neighbours.
  - After dir 7, go to POP.
- Stack: depth TOTAL_TILES. The queued bitmap guarantees no overflow; push and pop never occur in the same cycle.
- win: set when revealed_count == TOTAL_TILES-NUM_MINES while hit_mine=0.
- Latency, single non-zero tile: accept at edge 0, revealed bit set at edge 1, reveal_done high after edge 2.
- mine_map is sampled live and must not change while busy.

Optional Feature:
- Macro: REVEAL_MINES_ON_LOSS_EN.
- Defined: at the edge that sets hit_mine, revealed_map becomes revealed_map | mine_map. revealed_count is NOT updated.
- Undefined: only the hit tile's bit is set.

Decomposition:
- Package minesweeper_pkg holds:
  - GRID_SIZE default;
  - state enum (IDLE/POP/EXPAND);
  - the 8 direction row/column offset constants;
  - the tile-index typedef.
- One sub-module, neighbor_mine_counter: combinational; inputs mine_map and index; output 4-bit 3x3 mine count excluding centre, bounds-checked. The display stage can reuse it.

Test Plan:
- NUM_MINES=1, mine at 63, reveal 0 -> revealed_map=64'h7FFF_FFFF_FFFF_FFFF, revealed_count=63, win=1, one reveal_done pulse, busy low afterward.
- Mine at 9, reveal 0 (count 1) -> only bit 0 set; reveal_done two edges after acceptance; revealed_count=1.
- Mine at 9, reveal 9 -> bit 9 set, hit_mine=1, reveal_done same edge. A following reveal of 0 is ignored: no reveal_done, map unchanged.
- Mine at 63, flag on tile 27, reveal 0 -> all tiles except 27 and 63 revealed; bit 27 stays 0. A second reveal_req during busy is dropped.
- Assert rst mid-flood, then deassert and reveal 0 again -> all outputs 0 immediately; the repeated flood gives the same result as a fresh run.
- With REVEAL_MINES_ON_LOSS_EN defined, mines at {9,20}, reveal 20 -> revealed_map bits 9 and 20 set, revealed_count=0.
